// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV64 datapath logic group.
package alu_pkg;

  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] xlen_t;

endpackage : alu_pkg

// File: rtl/and_slice.sv
// One narrow AND lane; also reports whether any result bit in the lane is set.
module and_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         any
);

  assign s   = a & b;
  assign any = |s;

endmodule : and_slice

// File: rtl/and64b.sv
// 64-bit bitwise AND: combinational result and zero flag for the ALU mux,
// plus a one-cycle registered copy with a valid flag for the EX stage.
module and64b
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = XLEN,
  parameter int unsigned SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic [WIDTH-1:0] s_q,
  output logic             out_valid
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;

  logic [NSLICE-1:0] slice_any;

  // Slices are concatenated in bit order to form s; each also feeds the zero tree.
  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    and_slice #(
      .W (SLICE_W)
    ) u_and_slice (
      .a   (a[g*SLICE_W +: SLICE_W]),
      .b   (b[g*SLICE_W +: SLICE_W]),
      .s   (s[g*SLICE_W +: SLICE_W]),
      .any (slice_any[g])
    );
  end

  assign zero = ~|slice_any;

  // Registered path: result holds when idle, valid tracks the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= s;
      end
    end
  end

endmodule : and64b

// File: tb/tb_and64b.sv
// Self-checking bench for and64b: directed boundaries plus randomized traffic
// against a cycle-level reference model.
module tb_and64b;
  import alu_pkg::*;

  logic  clk;
  logic  rst_n;
  xlen_t a;
  xlen_t b;
  logic  in_valid;
  xlen_t s;
  logic  zero;
  xlen_t s_q;
  logic  out_valid;

  int checks;
  int errors;

  and64b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .zero      (zero),
    .s_q       (s_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 64'hDEAD_BEEF_1234_5678;
    b        = 64'hFFFF_0000_FFFF_0000;
    after_edge();
    after_edge();
    // assert reset between edges; registers must clear without a clock
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_q !== 64'h0) begin
      errors++;
      $display("FAIL reset_s_q got %h want %h", s_q, 64'h0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    // combinational path keeps working during reset
    checks++;
    if (s !== 64'hDEAD_0000_1234_0000) begin
      errors++;
      $display("FAIL reset_comb_s got %h want %h", s, 64'hDEAD_0000_1234_0000);
    end
    after_edge();
    checks++;
    if (out_valid !== 1'b0 || s_q !== 64'h0) begin
      errors++;
      $display("FAIL reset_held got s_q=%h v=%b want 0/0", s_q, out_valid);
    end
  endtask

  task automatic test_comb_exhaustive();
    xlen_t exp;
    in_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a = 64'(i);
        b = 64'(j);
        #10;
        exp = 64'(i & j);
        checks++;
        if (s !== exp || zero !== (exp == 64'h0)) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d got s=%h z=%b want s=%h z=%b",
                   i, j, s, zero, exp, exp == 64'h0);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    xlen_t ta [5];
    xlen_t tbv[5];
    xlen_t ts [5];
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[0] = 64'h8000_0000_0000_0001; ts[0] = 64'h8000_0000_0000_0001;
    ta[1] = 64'hAAAA_AAAA_AAAA_AAAA; tbv[1] = 64'h5555_5555_5555_5555; ts[1] = 64'h0;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[2] = 64'hFFFF_FFFF_FFFF_FFFF; ts[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    ta[3] = 64'h0;                   tbv[3] = 64'h1234_5678_9ABC_DEF0; ts[3] = 64'h0;
    ta[4] = 64'h8000_0000_0000_0000; tbv[4] = 64'hFFFF_FFFF_FFFF_FFFF; ts[4] = 64'h8000_0000_0000_0000;
    for (int k = 0; k < 5; k++) begin
      a = ta[k];
      b = tbv[k];
      #10;
      checks++;
      if (s !== ts[k] || zero !== (ts[k] == 64'h0)) begin
        errors++;
        $display("FAIL boundary_%0d got s=%h z=%b want s=%h z=%b",
                 k, s, zero, ts[k], ts[k] == 64'h0);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    a        = 64'hF0;
    b        = 64'h3C;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_edge_valid got %b want 0", out_valid);
    end
    after_edge();
    checks++;
    if (s_q !== 64'h30 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_result got s_q=%h v=%b want 30/1", s_q, out_valid);
    end
  endtask

  task automatic test_pulse();
    @(negedge clk);
    in_valid = 1'b0;
    a        = 64'hFFFF_FFFF_FFFF_FFFF;
    b        = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      after_edge();
      checks++;
      if (s_q !== 64'h30 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pulse_hold_%0d got s_q=%h v=%b want 30/0", k, s_q, out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid = 1'b1;
    a        = 64'h0F0F;
    b        = 64'hFFFF;
    #3;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    in_valid = 1'b0;
    after_edge();
    checks++;
    if (s_q !== 64'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_drop got s_q=%h v=%b want 0/0", s_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1;
    after_edge();
    checks++;
    if (s_q !== 64'h0F0F || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_first got s_q=%h v=%b want 0f0f/1", s_q, out_valid);
    end
  endtask

  task automatic test_random();
    xlen_t exp_q;
    logic  exp_v;
    xlen_t ra;
    xlen_t rb;
    logic  rv;
    exp_q = 64'h0F0F;
    exp_v = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rv = 1'($urandom_range(0, 1));
      a = ra;
      b = rb;
      in_valid = rv;
      #1;
      checks++;
      if (s !== (ra & rb) || zero !== ((ra & rb) == 64'h0)) begin
        errors++;
        $display("FAIL rand_comb n=%0d got s=%h z=%b want %h", n, s, zero, ra & rb);
      end
      // reference: the accepting edge captures a&b, an idle edge keeps it
      if (rv) exp_q = ra & rb;
      exp_v = rv;
      after_edge();
      checks++;
      if (out_valid !== exp_v || s_q !== exp_q) begin
        errors++;
        $display("FAIL rand_reg n=%0d got s_q=%h v=%b want %h/%b",
                 n, s_q, out_valid, exp_q, exp_v);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #25;
    test_reset();
    test_comb_exhaustive();
    test_boundaries();
    test_registered();
    test_pulse();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_and64b
